// File: rtl/conv_op_sequencer.sv
// Sequencer for one CNN convolution instruction: fetches input/kernel words, runs the
// convolution engine, then writes the result words back while stalling the core.
`timescale 1ns/1ps
module conv_op_sequencer #(
   parameter int IN_WORDS  = 8,
   parameter int K_WORDS   = 6,
   parameter int OUT_WORDS = 4,
   parameter int AW        = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [2:0]    funct3,
   input  logic [AW-1:0] in_base,
   input  logic [AW-1:0] k_base,
   input  logic [AW-1:0] out_base,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic          mem_re,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   input  logic [31:0]   mem_rdata,
   output logic [31:0]   mem_wdata,
   output logic          ld_valid,
   output logic          ld_sel,
   output logic [3:0]    ld_idx,
   output logic [31:0]   ld_data,
   output logic [2:0]    eng_mode,
   output logic          eng_start,
   input  logic          eng_done,
   output logic [1:0]    eng_rd_idx,
   input  logic [31:0]   eng_rd_data
);

   localparam int FETCH_N = IN_WORDS + K_WORDS;
   localparam int CW      = $clog2(FETCH_N + 1);
   localparam logic [CW-1:0] IN_LAST_N  = CW'(IN_WORDS);
   localparam logic [CW-1:0] FETCH_LAST = CW'(FETCH_N - 1);
   localparam logic [CW-1:0] OUT_LAST   = CW'(OUT_WORDS - 1);

   typedef enum logic [2:0] {IDLE, FETCH, TAIL, RUN, WAIT, WB, DONE} state_t;

   state_t        state;
   state_t        nextState;
   logic [CW-1:0] cnt;
   logic [CW-1:0] kIdx;
   logic [2:0]    modeReg;
   logic [AW-1:0] inBase;
   logic [AW-1:0] kBase;
   logic [AW-1:0] outBase;
   logic          errReg;
   logic          ldValidReg;
   logic          ldSelReg;
   logic [3:0]    ldIdxReg;
   logic          legal;

   assign legal = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b011);
   assign kIdx  = cnt - IN_LAST_N;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nextState;
   end

   // Counter is shared by FETCH (issue number) and WB (result word); it rests at zero
   // elsewhere so both phases start from index 0. Load strobes trail issues by one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         modeReg    <= '0;
         inBase     <= '0;
         kBase      <= '0;
         outBase    <= '0;
         errReg     <= 1'b0;
         ldValidReg <= 1'b0;
         ldSelReg   <= 1'b0;
         ldIdxReg   <= '0;
      end else begin
         errReg <= (state == IDLE) && start && !legal;
         if ((state == IDLE) && start && legal) begin
            modeReg <= funct3;
            inBase  <= in_base;
            kBase   <= k_base;
            outBase <= out_base;
         end
         if (((state == FETCH) && (cnt != FETCH_LAST)) || ((state == WB) && (cnt != OUT_LAST)))
            cnt <= cnt + 1'b1;
         else
            cnt <= '0;
         ldValidReg <= (state == FETCH);
         ldSelReg   <= (state == FETCH) && (cnt >= IN_LAST_N);
         if (state != FETCH)       ldIdxReg <= '0;
         else if (cnt < IN_LAST_N) ldIdxReg <= 4'(cnt);
         else                      ldIdxReg <= 4'(kIdx);
      end
   end

   always_comb begin
      nextState  = state;
      mem_re     = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      eng_start  = 1'b0;
      done       = 1'b0;
      eng_rd_idx = '0;
      case (state)
         IDLE: if (start && legal) nextState = FETCH;
         FETCH: begin
            mem_re = 1'b1;
            if (cnt < IN_LAST_N) mem_addr = inBase + AW'({cnt, 2'b00});
            else                 mem_addr = kBase + AW'({kIdx, 2'b00});
            if (cnt == FETCH_LAST) nextState = TAIL;
         end
         TAIL: nextState = RUN;
         RUN: begin
            eng_start = 1'b1;
            nextState = WAIT;
         end
         WAIT: if (eng_done) nextState = WB;
         WB: begin
            mem_we     = 1'b1;
            eng_rd_idx = 2'(cnt);
            mem_addr   = outBase + AW'({cnt, 2'b00});
            mem_wdata  = eng_rd_data;
            if (cnt == OUT_LAST) nextState = DONE;
         end
         DONE: begin
            done      = 1'b1;
            nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   assign busy     = (state != IDLE);
   assign err      = errReg;
   assign ld_valid = ldValidReg;
   assign ld_sel   = ldSelReg;
   assign ld_idx   = ldIdxReg;
   assign ld_data  = ldValidReg ? mem_rdata : 32'h0;
   assign eng_mode = modeReg;

endmodule
